interrupt_controller_v2: RTL and testbench

- Parametrised priority interrupt controller for NUM_IRQ sources; successor to the single-cycle OR-and-flush interrupt block.
- Adds per-source synchronisation, edge/level mode, masking, programmable priority with threshold, nesting via an in-service set, valid/ack handshake and end-of-interrupt.
- Sits between peripheral interrupt lines and the core's trap/exception entry logic.

---
 rtl/irq_pkg.sv | 33 +++
 rtl/irq_prio_arbiter.sv | 38 +++
 rtl/interrupt_controller_v2.sv | 184 ++++++++++++++++++
 tb/tb_interrupt_controller_v2.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : irq_pkg                                                |
// | Description : Shared types and helpers for interrupt_controller_v2:  |
// |               handshake FSM encoding and a max-priority reduction.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package irq_pkg;

  // Upper bounds that fix the width of the reduction helper's operands.
  localparam int MAX_IRQ    = 64;
  localparam int MAX_PRIO_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  typedef logic [MAX_IRQ-1:0][MAX_PRIO_W-1:0] prio_vec_t;

  // Highest priority among the sources selected by mask (0 when none).
  function automatic logic [MAX_PRIO_W-1:0] max_prio(input prio_vec_t prios,
                                                     input logic [MAX_IRQ-1:0] mask);
    logic [MAX_PRIO_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (mask[i] && (prios[i] > m)) m = prios[i];
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : irq_prio_arbiter                                       |
// | Description : Combinational priority pick over eligible sources.     |
// |               Highest priority wins, ties go to the lowest index.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module irq_prio_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 3,
  localparam int ID_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]        eligible,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_flat,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio,
  output logic                      any_valid
);

  // Strict '>' scanning upward keeps the first (lowest) index on a tie and
  // means a priority-0 source can never displace the empty result.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && (prio_flat[i*PRIO_W +: PRIO_W] > win_prio)) begin
        win_prio = prio_flat[i*PRIO_W +: PRIO_W];
        win_id   = ID_W'(i);
      end
    end
  end

  assign any_valid = (win_prio != '0);

endmodule
`default_nettype wire

// File: rtl/interrupt_controller_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : interrupt_controller_v2                                |
// | Description : Priority interrupt controller with input sync,         |
// |               edge/level modes, masking, threshold, nesting through  |
// |               an in-service set, valid/ack handshake and EOI.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module interrupt_controller_v2
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 32,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_IRQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_IRQ-1:0]        irq_in,
  input  logic [NUM_IRQ-1:0]        irq_enable,
  input  logic [NUM_IRQ-1:0]        irq_edge,
  input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio_cfg,
  input  logic [PRIO_W-1:0]         threshold,
  output logic                      irq_req,
  output logic [ID_W-1:0]           irq_id,
  output logic [PRIO_W-1:0]         irq_prio,
  input  logic                      irq_ack,
  input  logic                      eoi_valid,
  input  logic [ID_W-1:0]           eoi_id,
  output logic [NUM_IRQ-1:0]        pending,
  output logic [NUM_IRQ-1:0]        in_service,
  output logic [NUM_IRQ-1:0]        overrun,
  input  logic [NUM_IRQ-1:0]        overrun_clr
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_ff;
  logic [NUM_IRQ-1:0] sync_line;
  logic [NUM_IRQ-1:0] sync_d;
  logic [NUM_IRQ-1:0] rise_q;
  logic [NUM_IRQ-1:0] level_q;

  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] eoi_mask;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] in_service_nxt;
  logic [NUM_IRQ-1:0] overrun_nxt;
  logic [NUM_IRQ-1:0] eligible;
  logic               ack_fire;

  prio_vec_t              prio_ext;
  logic [MAX_IRQ-1:0]     svc_ext;
  logic [MAX_PRIO_W-1:0]  nest_max;
  logic [MAX_PRIO_W-1:0]  thr_ext;

  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic              win_valid;

  irq_state_e state;

  assign sync_line = sync_ff[SYNC_STAGES-1];

  // Metastability chain for the raw asynchronous lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= '0;
    else          sync_ff <= {sync_ff[SYNC_STAGES-2:0], irq_in};
  end

  // Registered edge/level detection on the synchronised lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d  <= '0;
      rise_q  <= '0;
      level_q <= '0;
    end else begin
      sync_d  <= sync_line;
      rise_q  <= sync_line & ~sync_d;
      level_q <= sync_line;
    end
  end

  assign ack_fire = (state == ST_REQ) && irq_ack;

  // One-hot decode of the acknowledged and completed source; ids beyond
  // NUM_IRQ match no bit and are therefore dropped.
  always_comb begin
    ack_mask = '0;
    eoi_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i] = ack_fire  && (irq_id == ID_W'(i));
      eoi_mask[i] = eoi_valid && (eoi_id == ID_W'(i));
    end
  end

  // Next-state of the pending/in-service/overrun sets. EOI clears before the
  // ack sets, so an ack and EOI on the same id leaves the bit set.
  always_comb begin
    pending_nxt    = (irq_edge & ((pending & ~ack_mask) | rise_q))
                   | (~irq_edge & level_q & ~in_service & ~ack_mask);
    in_service_nxt = (in_service & ~eoi_mask) | ack_mask;
    overrun_nxt    = (overrun & ~overrun_clr) | (irq_edge & rise_q & pending);
  end

  // Source status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      in_service <= '0;
      overrun    <= '0;
    end else begin
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Widen priorities so the nesting reduction and threshold compare run at
  // one common width regardless of PRIO_W.
  always_comb begin
    prio_ext = '0;
    svc_ext  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_ext[i] = MAX_PRIO_W'(irq_prio_cfg[i*PRIO_W +: PRIO_W]);
    end
    svc_ext[NUM_IRQ-1:0] = in_service;
  end

  assign nest_max = max_prio(prio_ext, svc_ext);
  assign thr_ext  = MAX_PRIO_W'(threshold);

  // A source competes only if it beats both the threshold and every source
  // currently in service.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = pending[i] && irq_enable[i] && !in_service[i]
                 && (prio_ext[i] > thr_ext) && (prio_ext[i] > nest_max);
    end
  end

  irq_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W)
  ) u_arbiter (
    .eligible  (eligible),
    .prio_flat (irq_prio_cfg),
    .win_id    (win_id),
    .win_prio  (win_prio),
    .any_valid (win_valid)
  );

  // Request handshake: the captured id/prio stay frozen until acked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      irq_req  <= 1'b0;
      irq_id   <= '0;
      irq_prio <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            irq_req  <= 1'b1;
            irq_id   <= win_id;
            irq_prio <= win_prio;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          irq_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_interrupt_controller_v2                             |
// | Description : Directed plus random bench with a cycle-level          |
// |               behavioural reference model of the controller.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_interrupt_controller_v2;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic [N-1:0]  irq_enable = '1;
  logic [N-1:0]  irq_edge = '1;
  logic [N*PW-1:0] irq_prio_cfg = '0;
  logic [PW-1:0] threshold = '0;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic [PW-1:0] irq_prio;
  logic          irq_ack = 1'b0;
  logic          eoi_valid = 1'b0;
  logic [IW-1:0] eoi_id = '0;
  logic [N-1:0]  pending;
  logic [N-1:0]  in_service;
  logic [N-1:0]  overrun;
  logic [N-1:0]  overrun_clr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller_v2 #(.NUM_IRQ(N), .PRIO_W(PW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .irq_enable(irq_enable),
    .irq_edge(irq_edge), .irq_prio_cfg(irq_prio_cfg), .threshold(threshold),
    .irq_req(irq_req), .irq_id(irq_id), .irq_prio(irq_prio), .irq_ack(irq_ack),
    .eoi_valid(eoi_valid), .eoi_id(eoi_id), .pending(pending),
    .in_service(in_service), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The line a source's pending logic sees at edge k is irq_in as sampled at
  // edge k-3 (two sync flops plus one detection register).
  logic [N-1:0] hist [5];
  logic [N-1:0] m_pend, m_svc, m_ovr;
  bit           m_req;
  int           m_id, m_prio;

  function automatic int prio_of(input int i);
    return int'(irq_prio_cfg[i*PW +: PW]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 5; s++) hist[s] = '0;
    m_pend = '0; m_svc = '0; m_ovr = '0;
    m_req = 0; m_id = 0; m_prio = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rise, lvl, np, nsvc, ovr_set;
    bit ack_now, acked;
    int nest, best, bestp, p;
    rise = hist[2] & ~hist[3];
    lvl  = hist[2];
    ack_now = m_req && irq_ack;
    nsvc = m_svc;
    if (eoi_valid) nsvc[eoi_id] = 1'b0;
    if (ack_now)   nsvc[m_id]   = 1'b1;
    ovr_set = '0;
    np = '0;
    for (int i = 0; i < N; i++) begin
      acked = ack_now && (m_id == i);
      if (irq_edge[i]) begin
        if (rise[i]) begin
          ovr_set[i] = m_pend[i];
          np[i] = 1'b1;
        end else begin
          np[i] = m_pend[i] && !acked;
        end
      end else begin
        np[i] = lvl[i] && !m_svc[i] && !acked;
      end
    end
    nest = 0;
    for (int i = 0; i < N; i++)
      if (m_svc[i] && prio_of(i) > nest) nest = prio_of(i);
    best = -1; bestp = 0;
    for (int i = 0; i < N; i++) begin
      p = prio_of(i);
      if (m_pend[i] && irq_enable[i] && !m_svc[i] && p > int'(threshold)
          && p > nest && p > bestp) begin
        best = i; bestp = p;
      end
    end
    if (m_req) begin
      if (ack_now) m_req = 0;
    end else if (best >= 0) begin
      m_req = 1; m_id = best; m_prio = bestp;
    end
    m_ovr  = (m_ovr & ~overrun_clr) | ovr_set;
    m_pend = np;
    m_svc  = nsvc;
    for (int s = 4; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = irq_in;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("req", 64'(irq_req), 64'(m_req));
    check("pending", 64'(pending), 64'(m_pend));
    check("in_service", 64'(in_service), 64'(m_svc));
    check("overrun", 64'(overrun), 64'(m_ovr));
    if (m_req) begin
      check("id", 64'(irq_id), 64'(m_id));
      check("prio", 64'(irq_prio), 64'(m_prio));
    end
  endtask

  // Called at a negedge; advances one clock and compares at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irq_in = '0; irq_ack = 0; eoi_valid = 0; overrun_clr = '0;
    irq_enable = '1; irq_edge = '1; irq_prio_cfg = '0; threshold = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_prio(input int src, input int p);
    irq_prio_cfg[src*PW +: PW] = PW'(p);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!irq_req && n < budget) begin
      tick();
      n++;
    end
    check("req_wait", 64'(irq_req), 64'd1);
  endtask

  task automatic serve(input int exp_id, input bit do_eoi);
    wait_req(20);
    check("serve_id", 64'(irq_id), 64'(exp_id));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    if (do_eoi) begin
      eoi_valid = 1'b1; eoi_id = IW'(exp_id); tick(); eoi_valid = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_req", 64'(irq_req), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_in_service", 64'(in_service), 64'd0);

    // Single edge source: latency, ack and EOI.
    set_prio(5, 3);
    irq_in[5] = 1'b1;
    repeat (4) tick();
    check("lat_pending", 64'(pending[5]), 64'd1);
    check("lat_req_early", 64'(irq_req), 64'd0);
    tick();
    check("lat_req", 64'(irq_req), 64'd1);
    check("lat_id", 64'(irq_id), 64'd5);
    check("lat_prio", 64'(irq_prio), 64'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_pending", 64'(pending[5]), 64'd0);
    check("ack_in_service", 64'(in_service[5]), 64'd1);
    eoi_valid = 1'b1; eoi_id = 5; tick(); eoi_valid = 1'b0;
    check("eoi_in_service", 64'(in_service[5]), 64'd0);

    // Priority order and lowest-index tie break.
    do_reset();
    set_prio(2, 4); set_prio(9, 4); set_prio(7, 6);
    irq_in[2] = 1; irq_in[9] = 1; irq_in[7] = 1;
    serve(7, 1); serve(2, 1); serve(9, 1);

    // Nesting.
    do_reset();
    set_prio(3, 2); set_prio(10, 5); set_prio(11, 5);
    irq_in[3] = 1;
    serve(3, 0);
    irq_in[10] = 1;
    serve(10, 0);
    irq_in[11] = 1;
    repeat (10) tick();
    check("nest_withheld", 64'(irq_req), 64'd0);
    eoi_valid = 1; eoi_id = 10; tick(); eoi_valid = 0;
    serve(11, 1);

    // Threshold.
    do_reset();
    threshold = 3'd4;
    set_prio(1, 4);
    irq_in[1] = 1;
    repeat (8) tick();
    check("thr_blocked", 64'(irq_req), 64'd0);
    set_prio(1, 5);
    serve(1, 1);

    // Overrun on a double pulse.
    do_reset();
    set_prio(6, 3);
    irq_in[6] = 1; repeat (3) tick();
    irq_in[6] = 0; repeat (3) tick();
    irq_in[6] = 1; repeat (6) tick();
    serve(6, 1);
    check("ovr_set", 64'(overrun[6]), 64'd1);
    repeat (10) tick();
    check("ovr_single_delivery", 64'(irq_req), 64'd0);
    overrun_clr[6] = 1; tick(); overrun_clr[6] = 0;
    check("ovr_clr", 64'(overrun[6]), 64'd0);

    // Level source re-requests after EOI; async reset mid-handshake.
    do_reset();
    irq_edge[4] = 0;
    set_prio(4, 3);
    irq_in[4] = 1;
    serve(4, 1);
    wait_req(20);
    check("lvl_rereq_id", 64'(irq_id), 64'd4);
    #2 reset_n = 1'b0;
    #1;
    check("async_req", 64'(irq_req), 64'd0);
    check("async_id", 64'(irq_id), 64'd0);
    check("async_prio", 64'(irq_prio), 64'd0);
    check("async_pending", 64'(pending), 64'd0);
    check("async_in_service", 64'(in_service), 64'd0);
    @(negedge clk);
    do_reset();

    // Random phase against the reference model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        irq_prio_cfg = {$urandom, $urandom, $urandom};
        irq_enable   = $urandom | $urandom;
        irq_edge     = $urandom;
        threshold    = PW'($urandom_range(0, 2));
      end
      irq_in = irq_in ^ ($urandom & $urandom & $urandom & $urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi_valid = ($urandom_range(0, 3) == 0);
      eoi_id = IW'($urandom);
      if (m_svc != '0 && $urandom_range(0, 1) == 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_svc[(int'(eoi_id) + k) % N]) begin
            eoi_id = IW'((int'(eoi_id) + k) % N);
            break;
          end
        end
      end
      overrun_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      tick();
    end
    irq_ack = 0; eoi_valid = 0; overrun_clr = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
